// File: rtl/program_loader_if.sv
// Byte-stream input and memory write port shared by the program loader and its neighbours.
// The master drives the stream and observes the memory port; the loader is the slave.
interface program_loader_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_write;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_address,
        input  mem_data,
        input  mem_write
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_address,
        output mem_data,
        output mem_write
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: takes a LEN/data/CHK framed image from a byte stream, writes it to program
// memory and holds the CPU in reset until the XOR checksum of the data bytes verifies.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RESET_HOLD = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    program_loader_if.slave bus,
    output logic            cpu_reset,
    output logic            busy,
    output logic            done,
    output logic            error
);
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StChk,
        StRelease,
        StDone,
        StError
    } state_e;

    state_e                state_q;
    logic                  in_ready_q;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-1:0] mem_address_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]      count_q;
    logic [HOLD_W-1:0]     hold_q;
    logic                  cpu_reset_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic xfer;
    logic len_ok;

    assign xfer   = bus.in_valid & in_ready_q;
    assign len_ok = (bus.in_data != '0) && (32'(bus.in_data) <= DEPTH);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            in_ready_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            wr_addr_q     <= '0;
            acc_q         <= '0;
            count_q       <= '0;
            hold_q        <= '0;
            cpu_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed by a data transfer.
            mem_write_q <= 1'b0;
            case (state_q)
                StIdle, StDone, StError: begin
                    if (start) begin
                        state_q     <= StLen;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                    end
                end
                StLen: begin
                    if (xfer) begin
                        if (len_ok) begin
                            state_q   <= StData;
                            count_q   <= CNT_W'(bus.in_data);
                            wr_addr_q <= '0;
                            acc_q     <= '0;
                        end else begin
                            state_q    <= StError;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        mem_write_q   <= 1'b1;
                        mem_address_q <= wr_addr_q;
                        mem_data_q    <= bus.in_data;
                        acc_q         <= acc_q ^ bus.in_data;
                        wr_addr_q     <= wr_addr_q + 1'b1;
                        count_q       <= count_q - 1'b1;
                        if (count_q == CNT_W'(1)) begin
                            state_q <= StChk;
                        end
                    end
                end
                StChk: begin
                    if (xfer) begin
                        in_ready_q <= 1'b0;
                        if (bus.in_data == acc_q) begin
                            state_q <= StRelease;
                            hold_q  <= HOLD_W'(RESET_HOLD - 1);
                        end else begin
                            state_q <= StError;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end
                    end
                end
                StRelease: begin
                    // Keep the core in reset a few more cycles so the last write settles.
                    if (hold_q == '0) begin
                        state_q     <= StDone;
                        cpu_reset_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b0;
                    cpu_reset_q <= 1'b1;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    error_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign cpu_reset       = cpu_reset_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
endmodule
